// File: rtl/g3_rule_inserter.sv
// Appends a rule entry to the tail of a linked chain in one G3 subset table, rejecting duplicate rule IDs.
// Optional G3_WRITE_VERIFY_EN: read back every table write and report VERIFY_FAIL on mismatch.
module g3_rule_inserter #(
  parameter int          TABLE_ENTRY_SIZE = 1023,
  parameter int          FREE_BASE        = 0,
  parameter int          MAX_CHAIN        = 16,
  parameter logic [10:0] NULL_IDX         = 11'h7FF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [159:0]  req_entry,
  input  logic [10:0]   req_head,
  input  logic          req_head_valid,
  output logic          resp_valid,
  output logic [2:0]    resp_status,
  output logic [10:0]   resp_index,
  output logic [10:0]   resp_head,
  output logic          tbl_we,
  output logic [10:0]   tbl_addr,
  output logic [170:0]  tbl_wdata,
  input  logic [170:0]  tbl_rdata,
  output logic [11:0]   free_count
);

  localparam int            CW       = $clog2(MAX_CHAIN + 1);
  localparam logic [11:0]   LAST_IDX = 12'(TABLE_ENTRY_SIZE);
  localparam logic [11:0]   BASE_IDX = 12'(FREE_BASE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CHAIN);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_FULL     = 3'd1;
  localparam logic [2:0] ST_DUP      = 3'd2;
  localparam logic [2:0] ST_TOO_LONG = 3'd3;
`ifdef G3_WRITE_VERIFY_EN
  localparam logic [2:0] ST_VERIFY   = 3'd4;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ALLOC, S_RD_REQ, S_RD_WAIT, S_CHECK,
    S_WR_NEW, S_WR_LINK, S_VF_REQ, S_VF_WAIT, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [11:0]    free_ptr_q, free_ptr_d;
  logic [159:0]   entry_q, entry_d;
  logic [10:0]    head_q, head_d;
  logic           hv_q, hv_d;
  logic [10:0]    cur_q, cur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [10:0]    tail_q, tail_d;
  logic [159:0]   tail_data_q, tail_data_d;
  logic [2:0]     status_q, status_d;
`ifdef G3_WRITE_VERIFY_EN
  logic           vlink_q, vlink_d;
`endif

  logic [170:0] new_word;
  logic [170:0] link_word;
  logic         done;

  assign new_word  = {NULL_IDX, entry_q};
  assign link_word = {free_ptr_q[10:0], tail_data_q};
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      free_ptr_q  <= BASE_IDX;
      entry_q     <= '0;
      head_q      <= '0;
      hv_q        <= 1'b0;
      cur_q       <= '0;
      cnt_q       <= '0;
      tail_q      <= '0;
      tail_data_q <= '0;
      status_q    <= ST_OK;
`ifdef G3_WRITE_VERIFY_EN
      vlink_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      free_ptr_q  <= free_ptr_d;
      entry_q     <= entry_d;
      head_q      <= head_d;
      hv_q        <= hv_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      tail_data_q <= tail_data_d;
      status_q    <= status_d;
`ifdef G3_WRITE_VERIFY_EN
      vlink_q     <= vlink_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    free_ptr_d  = free_ptr_q;
    entry_d     = entry_q;
    head_d      = head_q;
    hv_d        = hv_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    tail_data_d = tail_data_q;
    status_d    = status_q;
`ifdef G3_WRITE_VERIFY_EN
    vlink_d     = vlink_q;
`endif
    tbl_we      = 1'b0;
    tbl_addr    = '0;
    tbl_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          entry_d  = req_entry;
          head_d   = req_head;
          hv_d     = req_head_valid;
          status_d = ST_OK;
          state_d  = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (free_ptr_q > LAST_IDX) begin
          status_d = ST_FULL;
          state_d  = S_DONE;
        end else if (!hv_q) begin
          state_d = S_WR_NEW;
        end else begin
          cur_d   = head_q;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        tbl_addr = cur_q;
        cnt_d    = cnt_q + 1'b1;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tbl_addr = cur_q;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        // Duplicate test wins over end-of-chain so a matching tail is still rejected.
        tbl_addr = cur_q;
        if (tbl_rdata[159:149] == entry_q[159:149]) begin
          status_d = ST_DUP;
          state_d  = S_DONE;
        end else if (tbl_rdata[170:160] == NULL_IDX) begin
          tail_d      = cur_q;
          tail_data_d = tbl_rdata[159:0];
          state_d     = S_WR_NEW;
        end else if (cnt_q == CNT_MAX) begin
          status_d = ST_TOO_LONG;
          state_d  = S_DONE;
        end else begin
          cur_d   = tbl_rdata[170:160];
          state_d = S_RD_REQ;
        end
      end
      S_WR_NEW: begin
        tbl_we    = 1'b1;
        tbl_addr  = free_ptr_q[10:0];
        tbl_wdata = new_word;
`ifdef G3_WRITE_VERIFY_EN
        vlink_d   = 1'b0;
        state_d   = S_VF_REQ;
`else
        state_d   = hv_q ? S_WR_LINK : S_DONE;
`endif
      end
      S_WR_LINK: begin
        tbl_we    = 1'b1;
        tbl_addr  = tail_q;
        tbl_wdata = link_word;
`ifdef G3_WRITE_VERIFY_EN
        vlink_d   = 1'b1;
        state_d   = S_VF_REQ;
`else
        state_d   = S_DONE;
`endif
      end
`ifdef G3_WRITE_VERIFY_EN
      S_VF_REQ: begin
        tbl_addr = vlink_q ? tail_q : free_ptr_q[10:0];
        state_d  = S_VF_WAIT;
      end
      S_VF_WAIT: begin
        tbl_addr = vlink_q ? tail_q : free_ptr_q[10:0];
        if (tbl_rdata != (vlink_q ? link_word : new_word)) begin
          status_d = ST_VERIFY;
          state_d  = S_DONE;
        end else if (!vlink_q && hv_q) begin
          state_d = S_WR_LINK;
        end else begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (status_q == ST_OK) free_ptr_d = free_ptr_q + 12'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = done;
  assign resp_status = done ? status_q : 3'd0;
  assign resp_index  = (done && status_q == ST_OK) ? free_ptr_q[10:0] : 11'd0;

  // Empty chain: the new slot becomes the head on success, otherwise the head stays null.
  always_comb begin
    resp_head = '0;
    if (done) begin
      if (hv_q)                  resp_head = head_q;
      else if (status_q == ST_OK) resp_head = free_ptr_q[10:0];
      else                       resp_head = NULL_IDX;
    end
  end

  assign free_count = (free_ptr_q > LAST_IDX) ? 12'd0 : (LAST_IDX + 12'd1 - free_ptr_q);

endmodule

// File: tb/tb_g3_rule_inserter.sv
// Scoreboard bench for g3_rule_inserter: behavioural chain-walk model feeds expected writes and responses.
module tb_g3_rule_inserter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [159:0]  req_entry = '0;
  logic [10:0]   req_head = '0;
  logic          req_head_valid = 1'b0;
  logic          resp_valid;
  logic [2:0]    resp_status;
  logic [10:0]   resp_index;
  logic [10:0]   resp_head;
  logic          tbl_we;
  logic [10:0]   tbl_addr;
  logic [170:0]  tbl_wdata;
  logic [170:0]  tbl_rdata;
  logic [11:0]   free_count;

`ifdef G3_WRITE_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  g3_rule_inserter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_entry(req_entry),
    .req_head(req_head), .req_head_valid(req_head_valid),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_index(resp_index), .resp_head(resp_head),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Table model: registered read, bench backdoor writes funnelled through the same process.
  logic [170:0] mem [0:2047];
  logic         bd_we = 1'b0;
  logic [10:0]  bd_addr = '0;
  logic [170:0] bd_data = '0;

  always @(posedge clk) begin
    tbl_rdata <= mem[tbl_addr];
    if (tbl_we) mem[tbl_addr] <= tbl_wdata;
    if (bd_we)  mem[bd_addr]  <= bd_data;
  end

  typedef struct { logic [10:0] addr; logic [170:0] data; } wr_t;
  typedef struct { logic [2:0] st; logic [10:0] idx; logic [10:0] head; } rsp_t;

  wr_t  wr_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_fp = 0;

  task automatic check(input string tag, input logic [170:0] got, input logic [170:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t  w;
    rsp_t r;
    if (rst_n) begin
      if (tbl_we) begin
        if (wr_q.size() == 0) check("unexpected_we", 1'b1, 1'b0);
        else begin
          w = wr_q.pop_front();
          check("we_addr", 171'(tbl_addr), 171'(w.addr));
          check("we_data", tbl_wdata, w.data);
        end
      end
      if (resp_valid) begin
        if (rsp_q.size() == 0) check("unexpected_resp", 1'b1, 1'b0);
        else begin
          r = rsp_q.pop_front();
          $display("resp status=%0d index=%0d head=%0h", resp_status, resp_index, resp_head);
          check("resp_status", 171'(resp_status), 171'(r.st));
          if (r.st == 3'd0) check("resp_index", 171'(resp_index), 171'(r.idx));
          check("resp_head", 171'(resp_head), 171'(r.head));
        end
      end
    end
  end

  function automatic int exp_free();
    return (model_fp > 1023) ? 0 : 1024 - model_fp;
  endfunction

  // Reference: walk the chain in the table model and push expected writes/response; returns latency.
  task automatic model_insert(input logic [159:0] e, input logic [10:0] h, input logic hv, output int lat);
    rsp_t         r;
    logic [10:0]  cur;
    logic [170:0] d;
    int           n;
    bit           fin;
    r.idx = '0;
    r.st  = 3'd0;
    r.head = h;
    if (model_fp > 1023) begin
      r.st = 3'd1; r.head = hv ? h : 11'h7FF; lat = 2;
    end else if (!hv) begin
      wr_q.push_back('{addr: 11'(model_fp), data: {11'h7FF, e}});
      r.idx = 11'(model_fp); r.head = 11'(model_fp); lat = 3 + 2 * VX;
      model_fp++;
    end else begin
      cur = h; n = 0; fin = 0; lat = 0;
      while (!fin) begin
        n++;
        d = mem[cur];
        if (d[159:149] == e[159:149]) begin
          r.st = 3'd2; lat = 3 * n + 2; fin = 1;
        end else if (d[170:160] == 11'h7FF) begin
          wr_q.push_back('{addr: 11'(model_fp), data: {11'h7FF, e}});
          wr_q.push_back('{addr: cur, data: {11'(model_fp), d[159:0]}});
          r.idx = 11'(model_fp); lat = 3 * n + 4 + 4 * VX; fin = 1;
          model_fp++;
        end else if (n == 16) begin
          r.st = 3'd3; lat = 3 * n + 2; fin = 1;
        end else begin
          cur = d[170:160];
        end
      end
    end
    rsp_q.push_back(r);
  endtask

  function automatic logic [159:0] mk_entry(input logic [10:0] id);
    logic [159:0] e;
    e = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e[159:149] = id;
    return e;
  endfunction

  task automatic do_insert(input logic [10:0] id, input logic [10:0] h, input logic hv);
    logic [159:0] e;
    int lat, cyc;
    e = mk_entry(id);
    model_insert(e, h, hv, lat);
    @(negedge clk);
    check("ready_before", 171'(req_ready), 171'(1));
    req_entry = e; req_head = h; req_head_valid = hv; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_entry = mk_entry(11'($urandom)); req_head = 11'($urandom); req_head_valid = 1'($urandom);
    cyc = 1;
    while (!resp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 171'(cyc), 171'(lat));
    @(negedge clk);
    check("resp_pulse", 171'(resp_valid), 171'(0));
    check("ready_after", 171'(req_ready), 171'(1));
    check("free_count", 171'(free_count), 171'(exp_free()));
  endtask

  task automatic backdoor(input logic [10:0] a, input logic [170:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin : stim
    logic [159:0] e;
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_we", 171'(tbl_we), 171'(0));
    check("rst_resp_valid", 171'(resp_valid), 171'(0));
    check("rst_resp_status", 171'(resp_status), 171'(0));
    check("rst_tbl_addr", 171'(tbl_addr), 171'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 171'(req_ready), 171'(1));
    check("rst_free_count", 171'(free_count), 171'(1024));

    do_insert(11'd5, 11'd0, 1'b0);   // empty chain -> slot 0
    do_insert(11'd7, 11'd0, 1'b1);   // chain 0->1
    do_insert(11'd9, 11'd0, 1'b1);   // chain 0->1->2
    do_insert(11'd9, 11'd0, 1'b1);   // duplicate at tail
    do_insert(11'd5, 11'd0, 1'b1);   // duplicate at head
    check("head_next_ptr", 171'(mem[0][170:160]), 171'(1));
    check("tail_next_ptr", 171'(mem[2][170:160]), 171'(11'h7FF));

    backdoor(11'd3, {11'd4, mk_entry(11'd20)});
    backdoor(11'd4, {11'd3, mk_entry(11'd21)});
    do_insert(11'd30, 11'd3, 1'b1);  // cyclic chain -> TOO_LONG

    // Reset while the link write is on the bus: only the new-slot write may be seen.
    e = mk_entry(11'd40);
    wr_q.push_back('{addr: 11'd3, data: {11'h7FF, e}});
    @(negedge clk);
    req_entry = e; req_head = 11'd0; req_head_valid = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 11) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #2;
    check("wrlink_we", 171'(tbl_we), 171'(1));
    check("wrlink_addr", 171'(tbl_addr), 171'(2));
    rst_n = 1'b0;
    #1;
    check("async_we_drop", 171'(tbl_we), 171'(0));
    check("async_no_resp", 171'(resp_valid), 171'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_fp = 0;
    @(negedge clk);
    check("post_rst_ready", 171'(req_ready), 171'(1));
    check("post_rst_free", 171'(free_count), 171'(1024));
    $display("reset during link write: done");

    for (int i = 0; i < 1024; i++) do_insert(11'(i), 11'd0, 1'b0);
    check("full_free_count", 171'(free_count), 171'(0));
    do_insert(11'd77, 11'd0, 1'b0);  // FULL, empty chain
    do_insert(11'd78, 11'd5, 1'b1);  // FULL, non-empty chain

    repeat (3) @(negedge clk);
    check("wr_q_empty", 171'(wr_q.size()), 171'(0));
    check("rsp_q_empty", 171'(rsp_q.size()), 171'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
